// File: rtl/uart_pkg.sv
// Shared UART register map, status bit positions and scheduler state encoding.
package uart_pkg;

  localparam logic [31:0] UART_REG_CLK_DIV = 32'h0000_0000;
  localparam logic [31:0] UART_REG_STATUS  = 32'h0000_0004;
  localparam logic [31:0] UART_REG_DATA    = 32'h0000_0008;

  localparam int UART_STATUS_TX_IDLE = 0;
  localparam int UART_STATUS_RX_PEND = 1;
  localparam int UART_DATA_EMPTY     = 31;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_POLL,
    ST_TX_WRITE,
    ST_RX_READ,
    ST_RX_HOLD
  } uart_sched_state_t;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr_in, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N    = 2,
  parameter int IDXW = idx_width(N)
) (
  input  logic [N-1:0]    req_in,
  input  logic [IDXW-1:0] ptr_in,
  output logic [N-1:0]    grant_onehot_out,
  output logic [IDXW-1:0] grant_idx_out
);

  logic [N-1:0] upper_req;

  // Lowest request overall is the wrap-around fallback; lowest at/above the pointer wins if present.
  always_comb begin
    upper_req        = '0;
    grant_idx_out    = '0;
    grant_onehot_out = '0;
    for (int i = 0; i < N; i++) begin
      upper_req[i] = req_in[i] && (IDXW'(i) >= ptr_in);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req_in[i]) grant_idx_out = IDXW'(i);
    end
    if (|upper_req) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (upper_req[i]) grant_idx_out = IDXW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      grant_onehot_out[i] = (|req_in) && (grant_idx_out == IDXW'(i));
    end
  end

endmodule

// File: rtl/uart_scheduler.sv
// UART bus master: programs the divider, polls status, round-robins TX requesters, drains RX.
// Define UART_SCHED_RX_EN to build the receive path; otherwise RX outputs are tied to zero.
module uart_scheduler
  import uart_pkg::*;
#(
  parameter int          N         = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [15:0] CLK_DIV   = 16'd103
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   tx_valid_in,
  input  logic [8*N-1:0] tx_data_in,
  output logic [N-1:0]   tx_ready_out,
  output logic           rx_valid_out,
  output logic [7:0]     rx_data_out,
  input  logic           rx_ready_in,
  output logic [31:0]    address_out,
  output logic           sel_out,
  output logic           read_out,
  output logic [3:0]     write_mask_out,
  output logic [31:0]    write_value_out,
  input  logic [31:0]    read_value_in,
  input  logic           ready_in
);

  localparam int IDXW = idx_width(N);

  uart_sched_state_t state_q, state_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]   grant_q, grant_d;
  logic              rx_valid_q, rx_valid_d;
  logic [7:0]        rx_data_q, rx_data_d;

  logic [N-1:0]      arb_onehot;
  logic [IDXW-1:0]   arb_idx;
  logic [7:0]        tx_byte;
  logic              bus_done;
  logic              rx_pending;
  logic              unused_bits;

  rr_arbiter #(.N(N), .IDXW(IDXW)) u_arbiter (
    .req_in           (tx_valid_in),
    .ptr_in           (rr_ptr_q),
    .grant_onehot_out (arb_onehot),
    .grant_idx_out    (arb_idx)
  );

`ifdef UART_SCHED_RX_EN
  assign rx_pending  = read_value_in[UART_STATUS_RX_PEND];
  assign unused_bits = ^{read_value_in[30:8], arb_onehot};
`else
  assign rx_pending  = 1'b0;
  assign unused_bits = ^{read_value_in[31:1], rx_ready_in, arb_onehot};
`endif

  assign bus_done     = sel_out && ready_in;
  assign rx_valid_out = rx_valid_q;
  assign rx_data_out  = rx_data_q;

  always_comb begin
    tx_byte = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == IDXW'(i)) tx_byte = tx_data_in[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    case (state_q)
      ST_INIT: begin
        if (bus_done) state_d = ST_POLL;
      end
      ST_POLL: begin
        if (bus_done) begin
          if (rx_pending) begin
            state_d = ST_RX_READ;
          end else if (read_value_in[UART_STATUS_TX_IDLE] && (|tx_valid_in)) begin
            grant_d = arb_idx;
            state_d = ST_TX_WRITE;
          end
        end
      end
      ST_TX_WRITE: begin
        if (bus_done) begin
          rr_ptr_d = (grant_q == IDXW'(N - 1)) ? '0 : grant_q + 1'b1;
          state_d  = ST_POLL;
        end
      end
`ifdef UART_SCHED_RX_EN
      ST_RX_READ: begin
        if (bus_done) begin
          if (!read_value_in[UART_DATA_EMPTY]) begin
            rx_data_d  = read_value_in[7:0];
            rx_valid_d = 1'b1;
            state_d    = ST_RX_HOLD;
          end else begin
            state_d = ST_POLL;
          end
        end
      end
      ST_RX_HOLD: begin
        if (rx_valid_q && rx_ready_in) begin
          rx_valid_d = 1'b0;
          state_d    = ST_POLL;
        end
      end
`endif
      default: state_d = ST_INIT;
    endcase
  end

  // Bus outputs follow the state register; reset forces them idle so an in-flight access aborts at once.
  always_comb begin
    sel_out         = 1'b0;
    read_out        = 1'b0;
    write_mask_out  = 4'b0000;
    write_value_out = 32'h0;
    address_out     = BASE_ADDR;
    if (!reset) begin
      case (state_q)
        ST_INIT: begin
          sel_out         = 1'b1;
          address_out     = BASE_ADDR + UART_REG_CLK_DIV;
          write_mask_out  = 4'b0011;
          write_value_out = {16'b0, CLK_DIV};
        end
        ST_POLL: begin
          sel_out     = 1'b1;
          read_out    = 1'b1;
          address_out = BASE_ADDR + UART_REG_STATUS;
        end
        ST_TX_WRITE: begin
          sel_out         = 1'b1;
          address_out     = BASE_ADDR + UART_REG_DATA;
          write_mask_out  = 4'b0001;
          write_value_out = {24'b0, tx_byte};
        end
        ST_RX_READ: begin
          sel_out     = 1'b1;
          read_out    = 1'b1;
          address_out = BASE_ADDR + UART_REG_DATA;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_ready_out = '0;
    if (!reset && (state_q == ST_TX_WRITE) && ready_in) begin
      for (int i = 0; i < N; i++) begin
        tx_ready_out[i] = (grant_q == IDXW'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_scheduler.sv
// Scoreboard bench for uart_scheduler: per-cycle expected bus/handshake state queued by stimulus, popped by a monitor.
module tb_uart_scheduler;

  localparam logic [31:0] BASE = 32'h4000_0100;

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic        rd;
    logic [3:0]  mask;
    logic [31:0] wval;
    logic [1:0]  txr;
    logic        rxv;
    logic [7:0]  rxd;
  } obs_t;

  logic        clk;
  logic        reset;
  logic [1:0]  tx_valid_in;
  logic [15:0] tx_data_in;
  logic [1:0]  tx_ready_out;
  logic        rx_valid_out;
  logic [7:0]  rx_data_out;
  logic        rx_ready_in;
  logic [31:0] address_out;
  logic        sel_out;
  logic        read_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value_in;
  logic        ready_in;

  logic [31:0] status_val;
  logic [31:0] data_val;
  logic        stall;
  logic [7:0]  heldRx;

  obs_t  expQ[$];
  string nameQ[$];
  int    checkCount;
  int    passCount;

  uart_scheduler #(.N(2), .BASE_ADDR(BASE), .CLK_DIV(16'd103)) dut (
    .clk             (clk),
    .reset           (reset),
    .tx_valid_in     (tx_valid_in),
    .tx_data_in      (tx_data_in),
    .tx_ready_out    (tx_ready_out),
    .rx_valid_out    (rx_valid_out),
    .rx_data_out     (rx_data_out),
    .rx_ready_in     (rx_ready_in),
    .address_out     (address_out),
    .sel_out         (sel_out),
    .read_out        (read_out),
    .write_mask_out  (write_mask_out),
    .write_value_out (write_value_out),
    .read_value_in   (read_value_in),
    .ready_in        (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait UART slave model with an optional stall.
  assign ready_in      = sel_out && !stall;
  assign read_value_in = (address_out == BASE + 32'h4) ? status_val :
                         (address_out == BASE + 32'h8) ? data_val : 32'h0;

  function automatic obs_t mk(input logic s, input logic [31:0] off, input logic r,
                              input logic [3:0] m, input logic [31:0] w,
                              input logic [1:0] t, input logic v);
    obs_t o;
    o.sel  = s;
    o.addr = BASE + off;
    o.rd   = r;
    o.mask = m;
    o.wval = w;
    o.txr  = t;
    o.rxv  = v;
    o.rxd  = heldRx;
    return o;
  endfunction

  function automatic obs_t expReset();
    return mk(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 2'b00, 1'b0);
  endfunction
  function automatic obs_t expInit();
    return mk(1'b1, 32'h0, 1'b0, 4'b0011, 32'h0000_0067, 2'b00, 1'b0);
  endfunction
  function automatic obs_t expPoll();
    return mk(1'b1, 32'h4, 1'b1, 4'b0000, 32'h0, 2'b00, 1'b0);
  endfunction
  function automatic obs_t expTx(input logic [7:0] b, input logic [1:0] t);
    return mk(1'b1, 32'h8, 1'b0, 4'b0001, {24'h0, b}, t, 1'b0);
  endfunction
  function automatic obs_t expRxRead();
    return mk(1'b1, 32'h8, 1'b1, 4'b0000, 32'h0, 2'b00, 1'b0);
  endfunction
  function automatic obs_t expHold();
    return mk(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 2'b00, 1'b1);
  endfunction

  // Drives one cycle of inputs just after the edge and queues what the DUT must show in that cycle.
  task automatic applyStimulus(input logic rst, input logic [31:0] stat, input logic [1:0] v,
                               input logic [15:0] d, input logic rr, input logic [31:0] dv,
                               input logic st, input obs_t e, input string nm);
    @(posedge clk);
    #1;
    reset       = rst;
    status_val  = stat;
    tx_valid_in = v;
    tx_data_in  = d;
    rx_ready_in = rr;
    data_val    = dv;
    stall       = st;
    expQ.push_back(e);
    nameQ.push_back(nm);
  endtask

  task automatic checkOutput(input obs_t e, input string nm);
    obs_t a;
    a.sel  = sel_out;
    a.addr = address_out;
    a.rd   = read_out;
    a.mask = write_mask_out;
    a.wval = write_value_out;
    a.txr  = tx_ready_out;
    a.rxv  = rx_valid_out;
    a.rxd  = rx_data_out;
    checkCount++;
    if (a !== e) begin
      $display("[TB] FAIL %s: got sel=%b addr=%h rd=%b mask=%b wdata=%h txr=%b rxv=%b rxd=%h, want sel=%b addr=%h rd=%b mask=%b wdata=%h txr=%b rxv=%b rxd=%h",
               nm, a.sel, a.addr, a.rd, a.mask, a.wval, a.txr, a.rxv, a.rxd,
               e.sel, e.addr, e.rd, e.mask, e.wval, e.txr, e.rxv, e.rxd);
    end else begin
      passCount++;
    end
  endtask

  always @(negedge clk) begin
    obs_t  e;
    string nm;
    if (expQ.size() > 0) begin
      e  = expQ.pop_front();
      nm = nameQ.pop_front();
      checkOutput(e, nm);
    end
  end

  initial begin
    checkCount  = 0;
    passCount   = 0;
    heldRx      = 8'h00;
    reset       = 1'b1;
    status_val  = 32'h0;
    data_val    = 32'h0;
    tx_valid_in = 2'b00;
    tx_data_in  = 16'h0;
    rx_ready_in = 1'b0;
    stall       = 1'b0;

    applyStimulus(1, 32'h0, 2'b00, 16'h2241, 0, 32'h0, 0, expReset(), "reset idle 1");
    applyStimulus(1, 32'h0, 2'b00, 16'h2241, 0, 32'h0, 0, expReset(), "reset idle 2");
    applyStimulus(0, 32'h0, 2'b00, 16'h2241, 0, 32'h0, 0, expInit(),  "init divider write");
    applyStimulus(0, 32'h0, 2'b00, 16'h2241, 0, 32'h0, 0, expPoll(),  "poll busy");
    applyStimulus(0, 32'h1, 2'b01, 16'h2241, 0, 32'h0, 0, expPoll(),  "poll grant req0");
    applyStimulus(0, 32'h1, 2'b01, 16'h2241, 0, 32'h0, 0, expTx(8'h41, 2'b01), "tx write 41");
    applyStimulus(0, 32'h1, 2'b00, 16'h2241, 0, 32'h0, 0, expPoll(),  "poll after tx");
    applyStimulus(0, 32'h1, 2'b00, 16'h2241, 0, 32'h0, 0, expPoll(),  "poll no request");

    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 32'h1, 2'b11, 16'h2211, 0, 32'h0, 0, expPoll(), "rr poll a");
      applyStimulus(0, 32'h1, 2'b11, 16'h2211, 0, 32'h0, 0, expTx(8'h22, 2'b10), "rr grant 1");
      applyStimulus(0, 32'h1, 2'b11, 16'h2211, 0, 32'h0, 0, expPoll(), "rr poll b");
      applyStimulus(0, 32'h1, 2'b11, 16'h2211, 0, 32'h0, 0, expTx(8'h11, 2'b01), "rr grant 0");
    end
    applyStimulus(0, 32'h0, 2'b11, 16'h2211, 0, 32'h0, 0, expPoll(), "tx busy hold 1");
    applyStimulus(0, 32'h0, 2'b11, 16'h2211, 0, 32'h0, 0, expPoll(), "tx busy hold 2");
    applyStimulus(0, 32'h0, 2'b00, 16'h2233, 0, 32'h0, 0, expPoll(), "poll quiet");

`ifdef UART_SCHED_RX_EN
    applyStimulus(0, 32'h3, 2'b01, 16'h2233, 0, 32'h5A, 0, expPoll(),   "rx priority poll");
    applyStimulus(0, 32'h3, 2'b01, 16'h2233, 0, 32'h5A, 0, expRxRead(), "rx data read");
    heldRx = 8'h5A;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 32'h1, 2'b01, 16'h2233, 0, 32'h0, 0, expHold(), "rx hold stalled");
    end
    applyStimulus(0, 32'h1, 2'b01, 16'h2233, 1, 32'h0, 0, expHold(), "rx hold accept");
    applyStimulus(0, 32'h1, 2'b01, 16'h2233, 0, 32'h0, 0, expPoll(), "poll after rx");
    applyStimulus(0, 32'h1, 2'b01, 16'h2233, 0, 32'h0, 0, expTx(8'h33, 2'b01), "tx after rx wrap");
    applyStimulus(0, 32'h0, 2'b00, 16'h2233, 0, 32'h0, 0, expPoll(), "poll after tx2");
    applyStimulus(0, 32'h2, 2'b00, 16'h2233, 0, 32'hFFFF_FF00, 0, expPoll(),   "spurious poll");
    applyStimulus(0, 32'h0, 2'b00, 16'h2233, 0, 32'hFFFF_FF00, 0, expRxRead(), "spurious read");
    applyStimulus(0, 32'h0, 2'b00, 16'h2233, 0, 32'h0, 0, expPoll(), "spurious back to poll");
    applyStimulus(0, 32'h0, 2'b00, 16'h2233, 0, 32'h0, 0, expPoll(), "spurious no valid");
    applyStimulus(0, 32'h2, 2'b00, 16'h2233, 0, 32'hA5, 0, expPoll(),   "rx2 poll");
    applyStimulus(0, 32'h2, 2'b00, 16'h2233, 0, 32'hA5, 0, expRxRead(), "rx2 read");
    heldRx = 8'hA5;
    applyStimulus(1, 32'h0, 2'b00, 16'h2233, 0, 32'h0, 0, expHold(), "reset in hold");
    heldRx = 8'h00;
    applyStimulus(0, 32'h0, 2'b00, 16'h2233, 0, 32'h0, 0, expInit(), "reinit after hold reset");
    applyStimulus(0, 32'h0, 2'b00, 16'h2233, 0, 32'h0, 0, expPoll(), "poll after reinit");
`else
    applyStimulus(0, 32'h3, 2'b01, 16'h2233, 0, 32'h5A, 0, expPoll(), "poll rx ignored");
    applyStimulus(0, 32'h0, 2'b01, 16'h2233, 0, 32'h5A, 0, expTx(8'h33, 2'b01), "tx wrap grant 0");
    applyStimulus(0, 32'h0, 2'b00, 16'h2233, 0, 32'h0, 0, expPoll(), "poll after tx2");
    applyStimulus(0, 32'h2, 2'b00, 16'h2233, 0, 32'h5A, 0, expPoll(), "pending bit ignored");
    applyStimulus(0, 32'h0, 2'b00, 16'h2233, 0, 32'h0, 0, expPoll(), "still polling");
`endif

    applyStimulus(0, 32'h1, 2'b10, 16'h2233, 0, 32'h0, 0, expPoll(),  "poll grant req1");
    applyStimulus(1, 32'h1, 2'b10, 16'h2233, 0, 32'h0, 0, expReset(), "reset aborts tx");
    applyStimulus(0, 32'h1, 2'b10, 16'h2233, 0, 32'h0, 0, expInit(),  "reinit after tx abort");
    applyStimulus(0, 32'h1, 2'b10, 16'h2233, 0, 32'h0, 0, expPoll(),  "poll req1 again");
    applyStimulus(0, 32'h1, 2'b10, 16'h2233, 0, 32'h0, 0, expTx(8'h22, 2'b10), "tx req1 resent");
    applyStimulus(0, 32'h1, 2'b00, 16'h2233, 0, 32'h0, 0, expPoll(),  "poll idle");

    applyStimulus(0, 32'h1, 2'b01, 16'h2233, 0, 32'h0, 0, expPoll(), "poll before stall");
    applyStimulus(0, 32'h1, 2'b01, 16'h2233, 0, 32'h0, 1, expTx(8'h33, 2'b00), "tx stalled 1");
    applyStimulus(0, 32'h1, 2'b01, 16'h2233, 0, 32'h0, 1, expTx(8'h33, 2'b00), "tx stalled 2");
    applyStimulus(0, 32'h1, 2'b01, 16'h2233, 0, 32'h0, 0, expTx(8'h33, 2'b01), "tx stall release");
    applyStimulus(0, 32'h1, 2'b00, 16'h2233, 0, 32'h0, 0, expPoll(), "poll after stall");

    @(posedge clk);
    @(negedge clk);
    #1;
    checkCount++;
    if (expQ.size() != 0) begin
      $display("[TB] FAIL scoreboard drain: got %0d entries left, want 0", expQ.size());
    end else begin
      passCount++;
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
